// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: requester IDs and CDB packet field widths.
package cdb_arbiter_pkg;

    localparam int REQ_RS     = 0;
    localparam int REQ_LSB_LD = 1;
    localparam int REQ_LSB_ST = 2;

    localparam int VAL_W = 32;
    localparam int PC_W  = 32;
    localparam int BR_W  = 1;

    // Packet layout, MSB first: {rob_idx, val, actual_br, pc_jump}
    function automatic int pkt_width(input int rob_width);
        return rob_width + VAL_W + BR_W + PC_W;
    endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-producer result FIFO: QDEPTH packets, synchronous flush, registered occupancy count.
module cdb_req_fifo #(
    parameter int PW     = 69,
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [PW-1:0] push_data,
    output logic [PW-1:0] head_data,
    output logic [CW-1:0] count
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [PW-1:0]    mem [QDEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // Pointers are power-of-two wide, so they wrap without explicit modulo logic.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem[head_ptr];
    assign count     = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging N_REQ producer FIFOs onto a single registered common data bus.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int N_REQ     = 3,
    parameter int QDEPTH    = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       clr_in,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ROB_WIDTH-1:0] req_rob_idx,
    input  logic [N_REQ*VAL_W-1:0]     req_val,
    input  logic [N_REQ-1:0]           req_actual_br,
    input  logic [N_REQ*PC_W-1:0]      req_pc_jump,
    output logic                       cdb_valid,
    output logic [ROB_WIDTH-1:0]       cdb_rob_idx,
    output logic [VAL_W-1:0]           cdb_val,
    output logic                       cdb_actual_br,
    output logic [PC_W-1:0]            cdb_pc_jump,
    output logic [N_REQ-1:0]           cdb_src
);

    localparam int PW  = pkt_width(ROB_WIDTH);
    localparam int CW  = $clog2(QDEPTH) + 1;
    localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    head_data  [N_REQ];
    logic [CW-1:0]    fifo_count [N_REQ];
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] grant;
    logic [RRW-1:0]   rr;
    logic [RRW-1:0]   winner;
    logic [RRW-1:0]   rr_next;
    logic             any_cand;
    logic             enable;
    logic [PW-1:0]    win_pkt;

    assign enable = rdy_in & ~clr_in;

    for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
        assign req_ready[g] = (fifo_count[g] != CW'(QDEPTH));
        assign push[g]      = enable & req_valid[g] & req_ready[g];
        assign pop[g]       = enable & grant[g];

        cdb_req_fifo #(
            .PW     (PW),
            .QDEPTH (QDEPTH),
            .CW     (CW)
        ) u_fifo (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .flush     (clr_in),
            .push      (push[g]),
            .pop       (pop[g]),
            .push_data ({req_rob_idx[g*ROB_WIDTH +: ROB_WIDTH], req_val[g*VAL_W +: VAL_W],
                         req_actual_br[g], req_pc_jump[g*PC_W +: PC_W]}),
            .head_data (head_data[g]),
            .count     (fifo_count[g])
        );
    end

    // Scan from rr upward with wrap; the first non-empty FIFO wins.
    always_comb begin
        int cand;
        any_cand = 1'b0;
        winner   = '0;
        grant    = '0;
        cand     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!any_cand && fifo_count[cand] != '0) begin
                any_cand = 1'b1;
                winner   = RRW'(cand);
            end
        end
        if (any_cand) begin
            grant[winner] = 1'b1;
        end
    end

    assign rr_next = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    assign win_pkt = head_data[winner];

    // Data fields hold when nothing is broadcast; only valid/src drop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr            <= '0;
            cdb_valid     <= 1'b0;
            cdb_rob_idx   <= '0;
            cdb_val       <= '0;
            cdb_actual_br <= 1'b0;
            cdb_pc_jump   <= '0;
            cdb_src       <= '0;
        end else if (clr_in) begin
            rr        <= '0;
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
        end else if (rdy_in) begin
            if (any_cand) begin
                rr        <= rr_next;
                cdb_valid <= 1'b1;
                cdb_src   <= grant;
                {cdb_rob_idx, cdb_val, cdb_actual_br, cdb_pc_jump} <= win_pkt;
            end else begin
                cdb_valid <= 1'b0;
                cdb_src   <= '0;
            end
        end
    end

endmodule
